// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and config field widths.
package led_pkg;

    localparam int unsigned CFG_CH_W = 4;
    localparam int unsigned MODE_W   = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'd3;

    // Modes that run the period counter.
    function automatic logic is_counting_mode(input logic [MODE_W-1:0] mode);
        return (mode == MODE_BLINK) || (mode == MODE_PWM);
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: shadow/active config, period counter, boundary commit and registered LED flop.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic              pending,
    output logic              led
);

    logic [MODE_W-1:0] r_sh_mode;
    logic [CNT_W-1:0]  r_sh_period;
    logic [CNT_W-1:0]  r_sh_duty;
    logic              r_pending;
    logic [MODE_W-1:0] r_mode;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_duty;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_led;

    logic              w_run;
    logic [CNT_W-1:0]  w_last;
    logic              w_wrap;
    logic              w_commit;
    logic [MODE_W-1:0] w_mode_nxt;
    logic [CNT_W-1:0]  w_duty_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_led_nxt;

    // Counter position, boundary detection and commit decision.
    always_comb begin
        w_run      = enable && is_counting_mode(r_mode);
        w_last     = (r_period == '0) ? '0 : (r_period - CNT_W'(1));
        w_wrap     = w_run && (r_cnt >= w_last);
        w_commit   = r_pending && (!w_run || w_wrap);
        w_mode_nxt = w_commit ? r_sh_mode : r_mode;
        w_duty_nxt = w_commit ? r_sh_duty : r_duty;
        w_cnt_nxt  = '0;
        if (!w_commit && w_run && !w_wrap) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // LED next value; a BLINK->BLINK commit only happens on a wrap, so it keeps toggling.
    always_comb begin
        w_led_nxt = 1'b0;
        if (enable) begin
            case (w_mode_nxt)
                MODE_OFF:   w_led_nxt = 1'b0;
                MODE_ON:    w_led_nxt = 1'b1;
                MODE_BLINK: begin
                    if (w_commit && (r_mode != MODE_BLINK)) begin
                        w_led_nxt = 1'b0;
                    end else if (w_wrap) begin
                        w_led_nxt = ~r_led;
                    end else begin
                        w_led_nxt = r_led;
                    end
                end
                default:    w_led_nxt = (w_cnt_nxt < w_duty_nxt);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_mode   <= MODE_OFF;
            r_sh_period <= CNT_W'(DEF_PERIOD);
            r_sh_duty   <= '0;
            r_pending   <= 1'b0;
            r_mode      <= MODE_OFF;
            r_period    <= CNT_W'(DEF_PERIOD);
            r_duty      <= '0;
            r_cnt       <= '0;
            r_led       <= 1'b0;
        end else begin
            if (w_commit) begin
                r_mode   <= r_sh_mode;
                r_period <= r_sh_period;
                r_duty   <= r_sh_duty;
            end
            // A write on the commit edge stays pending for the next boundary.
            if (wr) begin
                r_sh_mode   <= cfg_mode;
                r_sh_period <= cfg_period;
                r_sh_duty   <= cfg_duty;
                r_pending   <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            r_cnt <= w_cnt_nxt;
            r_led <= w_led_nxt;
        end
    end

    assign pending = r_pending;
    assign led     = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: decodes config writes into per-channel strobes and flags out-of-range targets.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     enable,
    input  logic                cfg_wr,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_duty,
    output logic                cfg_err,
    output logic [N_CH-1:0]     pending,
    output logic [N_CH-1:0]     led
);

    localparam int unsigned CH_CMP_W = CFG_CH_W + 1;

    logic r_cfg_err;
    logic w_ch_bad;

    // Extra bit keeps the range check meaningful even when N_CH covers every index.
    assign w_ch_bad = ({1'b0, cfg_ch} >= CH_CMP_W'(N_CH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && w_ch_bad;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        logic w_wr;
        assign w_wr = cfg_wr && (cfg_ch == CFG_CH_W'(g));

        led_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable[g]),
            .wr         (w_wr),
            .cfg_mode   (cfg_mode),
            .cfg_period (cfg_period),
            .cfg_duty   (cfg_duty),
            .pending    (pending[g]),
            .led        (led[g])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a cycle model queues expected outputs, compared after each edge.
module tb_led_pattern_gen;

    localparam int N_CH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  enable;
    logic        cfg_wr;
    logic [3:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_period;
    logic [31:0] cfg_duty;
    logic        cfg_err;
    logic [3:0]  pending;
    logic [3:0]  led;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(.N_CH(4), .CNT_W(32), .DEF_PERIOD(25000000)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_err(cfg_err), .pending(pending), .led(led)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0]  m_mode [N_CH];
    logic [1:0]  m_smode[N_CH];
    logic [31:0] m_per  [N_CH];
    logic [31:0] m_sper [N_CH];
    logic [31:0] m_duty [N_CH];
    logic [31:0] m_sduty[N_CH];
    logic [31:0] m_cnt  [N_CH];
    logic        m_pend [N_CH];
    logic        m_led  [N_CH];
    logic        m_err;

    logic [8:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = 2'd0; m_smode[c] = 2'd0;
            m_per[c] = 32'd25000000; m_sper[c] = 32'd25000000;
            m_duty[c] = 0; m_sduty[c] = 0; m_cnt[c] = 0;
            m_pend[c] = 1'b0; m_led[c] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [8:0] e;
        for (int c = 0; c < N_CH; c++) begin
            logic counting, at_end, do_commit;
            logic [1:0] old_mode;
            longint ep;
            counting  = enable[c] && (m_mode[c] == 2'd2 || m_mode[c] == 2'd3);
            ep        = (m_per[c] == 0) ? 1 : longint'(m_per[c]);
            at_end    = counting && (longint'(m_cnt[c]) >= ep - 1);
            do_commit = m_pend[c] && (!counting || at_end);
            old_mode  = m_mode[c];
            if (do_commit) begin
                m_mode[c] = m_smode[c]; m_per[c] = m_sper[c]; m_duty[c] = m_sduty[c];
                m_pend[c] = 1'b0; m_cnt[c] = 0;
            end else if (counting) begin
                m_cnt[c] = at_end ? 0 : m_cnt[c] + 1;
            end else begin
                m_cnt[c] = 0;
            end
            if (cfg_wr && int'(cfg_ch) == c) begin
                m_smode[c] = cfg_mode; m_sper[c] = cfg_period; m_sduty[c] = cfg_duty;
                m_pend[c] = 1'b1;
            end
            if (!enable[c]) m_led[c] = 1'b0;
            else case (m_mode[c])
                2'd0: m_led[c] = 1'b0;
                2'd1: m_led[c] = 1'b1;
                2'd2: m_led[c] = (do_commit && old_mode != 2'd2) ? 1'b0 :
                                 (at_end ? ~m_led[c] : m_led[c]);
                default: m_led[c] = (m_cnt[c] < m_duty[c]);
            endcase
        end
        m_err = cfg_wr && (int'(cfg_ch) >= N_CH);
        for (int c = 0; c < N_CH; c++) begin
            e[c]     = m_led[c];
            e[4 + c] = m_pend[c];
        end
        e[8] = m_err;
        exp_q.push_back(e);
    endtask

    // One clock: predict, clock, then compare the oldest prediction against the DUT.
    task automatic cyc();
        logic [8:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("led",  32'(led),     32'(e[3:0]));
            chk("pend", 32'(pending), 32'(e[7:4]));
            chk("err",  32'(cfg_err), 32'(e[8]));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr_cfg(input logic [3:0] ch, input logic [1:0] mode,
                          input logic [31:0] per, input logic [31:0] duty);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
        cyc();
        cfg_wr = 1'b0;
    endtask

    logic [7:0] pat8;
    logic [9:0] pat10;

    initial begin
        rst = 1'b0; enable = 4'h0; cfg_wr = 1'b0; cfg_ch = 4'd0;
        cfg_mode = 2'd0; cfg_period = 0; cfg_duty = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led",  32'(led), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_err",  32'(cfg_err), 32'h0);
        rst = 1'b1;

        // Enabled, no writes: everything stays dark
        enable = 4'hF;
        run(6);
        chk("idle_led", 32'(led), 32'h0);

        // ch0 BLINK period 4
        wr_cfg(4'd0, 2'd2, 32'd4, 32'd0);
        chk("blink_pend_set", 32'(pending[0]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            pat8[i] = led[0];
        end
        chk("blink4_pat", 32'(pat8), 32'h0F0);

        // ch1 PWM period 10 duty 3
        wr_cfg(4'd1, 2'd3, 32'd10, 32'd3);
        for (int i = 0; i < 10; i++) begin
            cyc();
            pat10[i] = led[1];
        end
        chk("pwm3_pat", 32'(pat10), 32'h007);
        run(10);

        wr_cfg(4'd1, 2'd3, 32'd10, 32'd0);
        run(25);
        chk("pwm_duty0", 32'(led[1]), 32'd0);
        wr_cfg(4'd1, 2'd3, 32'd10, 32'd12);
        run(25);
        chk("pwm_duty12", 32'(led[1]), 32'd1);

        // ch3 ON, then shrink ch0 period mid-run
        wr_cfg(4'd3, 2'd1, 32'd5, 32'd0);
        wr_cfg(4'd0, 2'd2, 32'd8, 32'd0);
        run(13);
        wr_cfg(4'd0, 2'd2, 32'd2, 32'd0);
        run(20);
        wr_cfg(4'd2, 2'd2, 32'd0, 32'd0);
        run(6);

        // Out-of-range channel
        wr_cfg(4'd5, 2'd1, 32'd1, 32'd1);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        cyc();
        chk("err_clear", 32'(cfg_err), 32'd0);

        // ch2 BLINK period 3, then drop its enable
        wr_cfg(4'd2, 2'd2, 32'd3, 32'd0);
        run(11);
        enable[2] = 1'b0;
        cyc();
        chk("en_drop_led", 32'(led[2]), 32'd0);
        run(5);
        enable[2] = 1'b1;
        run(12);

        // Random writes across channels with random enables
        for (int i = 0; i < 40; i++) begin
            enable = 4'($urandom_range(0, 15)) | 4'h1;
            wr_cfg(4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                   32'($urandom_range(0, 6)), 32'($urandom_range(0, 7)));
            run(int'($urandom_range(0, 9)));
        end
        enable = 4'hF;
        run(10);

        // Async reset mid-period
        rst = 1'b0;
        #2;
        chk("mid_rst_led",  32'(led), 32'h0);
        chk("mid_rst_pend", 32'(pending), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(12);
        chk("post_rst_off", 32'(led), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
